// File: rtl/cnt_pkg.sv
// Shared types and helpers for the step/address counter.
package cnt_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } step_mode_e;

    // Add/subtract at MAX_WIDTH+1 bits; callers truncate to WIDTH+1 for carry/borrow at bit WIDTH.
    function automatic logic [MAX_WIDTH:0] addsub_raw(
        input logic [MAX_WIDTH:0] a,
        input logic [MAX_WIDTH:0] b,
        input logic               sub
    );
        return sub ? (a - b) : (a + b);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] all_ones(input int unsigned w);
        logic [MAX_WIDTH-1:0] m;
        m = '1;
        return m >> (MAX_WIDTH - w);
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit add/subtract with carry/borrow out and limit-hit detection.
module addsub_core
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] limit,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             hit
);

    logic [WIDTH:0] raw;

    assign raw    = (WIDTH+1)'(addsub_raw((MAX_WIDTH+1)'(a), (MAX_WIDTH+1)'(b), sub));
    assign result = raw[WIDTH-1:0];
    assign cout   = raw[WIDTH];

    // Hit is judged on the unbounded result: the step reaches limit when it covers the gap.
    always_comb begin
        hit = (a == limit) && (b == '0);
        if (sub) begin
            if ((a > limit) && (b >= (a - limit))) begin
                hit = 1'b1;
            end
        end else begin
            if ((a < limit) && (b >= (limit - a))) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_counter_addsub.sv
// Registered WIDTH-bit step counter: add/sub step with wrap or saturate, limit pulse and auto-reload.
module step_counter_addsub
    import cnt_pkg::*;
#(
    parameter int unsigned      WIDTH     = 9,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             MasterClock,
    input  logic             RESET,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             sub,
    input  logic [WIDTH-1:0] step,
    input  logic             sat,
    input  logic [WIDTH-1:0] limit,
    input  logic             reload_en,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             tc,
    output logic             busy_sat
);

    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(all_ones(WIDTH));

    logic [WIDTH-1:0] sum;
    logic             sum_cout;
    logic             limit_hit;
    step_mode_e       mode;

    logic [WIDTH-1:0] count_nxt;
    logic             carry_nxt;
    logic             tc_nxt;
    logic             busy_nxt;

    addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (count),
        .b      (step),
        .limit  (limit),
        .sub    (sub),
        .result (sum),
        .cout   (sum_cout),
        .hit    (limit_hit)
    );

    assign mode = sat ? SAT : WRAP;

    // Next-state selection: load beats step beats hold.
    always_comb begin
        count_nxt = count;
        carry_nxt = carry;
        tc_nxt    = 1'b0;
        busy_nxt  = busy_sat;
        if (load) begin
            count_nxt = load_val;
            carry_nxt = 1'b0;
            busy_nxt  = 1'b0;
        end else if (en) begin
            carry_nxt = sum_cout;
            if ((mode == SAT) && sum_cout) begin
                count_nxt = sub ? '0 : ALL_ONES;
                busy_nxt  = 1'b1;
            end else begin
                count_nxt = sum;
                busy_nxt  = 1'b0;
            end
            if (limit_hit) begin
                tc_nxt = 1'b1;
                if (reload_en) begin
                    count_nxt = load_val;
                    busy_nxt  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge MasterClock) begin
        if (RESET) begin
            count    <= RESET_VAL;
            carry    <= 1'b0;
            tc       <= 1'b0;
            busy_sat <= 1'b0;
        end else begin
            count    <= count_nxt;
            carry    <= carry_nxt;
            tc       <= tc_nxt;
            busy_sat <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_step_counter_addsub.sv
// Bench for step_counter_addsub: directed vector table on WIDTH=9, then random vs a model on WIDTH 9 and 16.
module tb_step_counter_addsub;

    typedef struct {
        bit          rst;
        bit          load;
        bit          en;
        bit          sub;
        bit          sat;
        bit          rel;
        int unsigned lv;
        int unsigned st;
        int unsigned lim;
    } in_t;

    typedef struct {
        int unsigned count;
        bit          carry;
        bit          tc;
        bit          busy;
    } st_t;

    typedef struct {
        in_t in;
        st_t exp;
    } vec_t;

    logic clk;
    int   n_checks;
    int   n_fail;

    logic       rst9, load9, en9, sub9, sat9, rel9;
    logic [8:0] lv9, st9, lim9, count9;
    logic       carry9, tc9, busy9;

    logic        rst16, load16, en16, sub16, sat16, rel16;
    logic [15:0] lv16, st16, lim16, count16;
    logic        carry16, tc16, busy16;

    st_t q9[$];
    st_t q16[$];
    vec_t vecs[$];

    step_counter_addsub #(.WIDTH(9), .RESET_VAL(9'd0)) dut9 (
        .MasterClock (clk),
        .RESET       (rst9),
        .load        (load9),
        .load_val    (lv9),
        .en          (en9),
        .sub         (sub9),
        .step        (st9),
        .sat         (sat9),
        .limit       (lim9),
        .reload_en   (rel9),
        .count       (count9),
        .carry       (carry9),
        .tc          (tc9),
        .busy_sat    (busy9)
    );

    step_counter_addsub #(.WIDTH(16), .RESET_VAL(16'd0)) dut16 (
        .MasterClock (clk),
        .RESET       (rst16),
        .load        (load16),
        .load_val    (lv16),
        .en          (en16),
        .sub         (sub16),
        .step        (st16),
        .sat         (sat16),
        .limit       (lim16),
        .reload_en   (rel16),
        .count       (count16),
        .carry       (carry16),
        .tc          (tc16),
        .busy_sat    (busy16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference behaviour computed on unbounded integers.
    function automatic st_t model(input int unsigned w, input st_t s, input in_t v);
        longint mask;
        longint c;
        longint stp;
        longint l;
        longint m;
        bit     ovf;
        bit     hit;
        st_t    n;
        mask  = (longint'(1) << w) - 1;
        c     = longint'(s.count);
        stp   = longint'(v.st);
        l     = longint'(v.lim);
        n     = s;
        n.tc  = 1'b0;
        if (v.rst) begin
            n.count = 0;
            n.carry = 1'b0;
            n.busy  = 1'b0;
        end else if (v.load) begin
            n.count = v.lv;
            n.carry = 1'b0;
            n.busy  = 1'b0;
        end else if (v.en) begin
            m   = v.sub ? (c - stp) : (c + stp);
            ovf = v.sub ? (m < 0) : (m > mask);
            if (v.sub) hit = ((c > l) && (m <= l)) || ((c == l) && (stp == 0));
            else       hit = ((c < l) && (m >= l)) || ((c == l) && (stp == 0));
            n.carry = ovf;
            if (v.sat && ovf) begin
                n.count = v.sub ? 0 : 32'(mask);
                n.busy  = 1'b1;
            end else begin
                n.count = 32'(m & mask);
                n.busy  = 1'b0;
            end
            if (hit) begin
                n.tc = 1'b1;
                if (v.rel) begin
                    n.count = v.lv;
                    n.busy  = 1'b0;
                end
            end
        end
        return n;
    endfunction

    function automatic in_t gen(input int unsigned w);
        in_t         v;
        int unsigned mask;
        int unsigned pick;
        mask  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        v.rst  = ($urandom_range(63) == 0);
        v.load = ($urandom_range(15) == 0);
        v.en   = ($urandom_range(3) != 0);
        v.sub  = 1'($urandom_range(1));
        v.sat  = 1'($urandom_range(1));
        v.rel  = ($urandom_range(3) == 0);
        v.lv   = $urandom & mask;
        pick   = $urandom_range(7);
        if (pick == 0)      v.st = 0;
        else if (pick < 5)  v.st = $urandom_range(7);
        else                v.st = $urandom & mask;
        v.lim  = $urandom & mask;
        return v;
    endfunction

    function automatic vec_t mk(input bit rst, input bit load, input bit en, input bit sub,
                                input bit sat, input bit rel, input int unsigned lv,
                                input int unsigned st, input int unsigned lim,
                                input int unsigned ec, input bit ecar, input bit etc,
                                input bit ebusy);
        vec_t x;
        x.in.rst = rst;  x.in.load = load; x.in.en = en;   x.in.sub = sub;
        x.in.sat = sat;  x.in.rel = rel;   x.in.lv = lv;   x.in.st = st;
        x.in.lim = lim;
        x.exp.count = ec; x.exp.carry = ecar; x.exp.tc = etc; x.exp.busy = ebusy;
        return x;
    endfunction

    task automatic drive9(input in_t v);
        rst9 = v.rst; load9 = v.load; en9 = v.en; sub9 = v.sub; sat9 = v.sat; rel9 = v.rel;
        lv9 = 9'(v.lv); st9 = 9'(v.st); lim9 = 9'(v.lim);
    endtask

    task automatic drive16(input in_t v);
        rst16 = v.rst; load16 = v.load; en16 = v.en; sub16 = v.sub; sat16 = v.sat; rel16 = v.rel;
        lv16 = 16'(v.lv); st16 = 16'(v.st); lim16 = 16'(v.lim);
    endtask

    task automatic check(input string name, input st_t e, input int unsigned cnt,
                         input bit car, input bit t, input bit b);
        n_checks += 4;
        if (cnt != e.count) begin
            n_fail++;
            $display("FAIL %s count: got 0x%0h expected 0x%0h", name, cnt, e.count);
        end
        if (car != e.carry) begin
            n_fail++;
            $display("FAIL %s carry: got %0d expected %0d", name, car, e.carry);
        end
        if (t != e.tc) begin
            n_fail++;
            $display("FAIL %s tc: got %0d expected %0d", name, t, e.tc);
        end
        if (b != e.busy) begin
            n_fail++;
            $display("FAIL %s busy_sat: got %0d expected %0d", name, b, e.busy);
        end
    endtask

    initial begin
        st_t  m9;
        st_t  m16;
        st_t  e;
        in_t  v9;
        in_t  v16;
        n_checks = 0;
        n_fail   = 0;

        //            rst ld en sb st rl  lv     step   lim     exp    c  tc bs
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,     0,     0,      0,     0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9'h155, 0,    0,      9'h155, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,     0,     0,      0,     0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9'h1F0, 0,    0,      9'h1F0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,     9'h020, 0,     9'h010, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,     9'h020, 0,     9'h030, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9'h005, 0,    9'h1FF, 9'h005, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0,     9'h008, 9'h1FF, 9'h000, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0,     9'h003, 9'h1FF, 9'h003, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,     0,     9'h00A, 9'h000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 9'h100, 4,    9'h00A, 9'h004, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 9'h100, 4,    9'h00A, 9'h008, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 9'h100, 4,    9'h00A, 9'h100, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 9'h100, 4,    9'h00A, 9'h104, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 9'h100, 4,    9'h00A, 9'h104, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 9'h0AA, 4,    9'h0AC, 9'h0AA, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 9'h055, 0,    0,      9'h000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,     0,     0,      9'h000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9'h1FE, 0,    0,      9'h1FE, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0,     5,     9'h1FF, 9'h1FF, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,     5,     9'h1FF, 9'h1FF, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9'h1FE, 0,    0,      9'h1FE, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,     4,     9'h1FF, 9'h002, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0,     4,     9'h1FF, 9'h1FE, 1, 0, 0));

        v16 = '{default: 0};
        v16.rst = 1'b1;
        drive16(v16);

        foreach (vecs[i]) begin
            drive9(vecs[i].in);
            q9.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            e = q9.pop_front();
            check($sformatf("vec%0d", i), e, 32'(count9), carry9, tc9, busy9);
        end

        m9  = '{default: 0};
        m16 = '{default: 0};
        for (int i = 0; i < 10000; i++) begin
            v9  = gen(9);
            v16 = gen(16);
            if (i == 0) begin
                v9.rst  = 1'b1;
                v16.rst = 1'b1;
            end
            drive9(v9);
            drive16(v16);
            m9  = model(9, m9, v9);
            m16 = model(16, m16, v16);
            q9.push_back(m9);
            q16.push_back(m16);
            @(posedge clk);
            #1;
            e = q9.pop_front();
            check($sformatf("rnd9_%0d", i), e, 32'(count9), carry9, tc9, busy9);
            e = q16.pop_front();
            check($sformatf("rnd16_%0d", i), e, 32'(count16), carry16, tc16, busy16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/step_counter_addsub.md
Name: step_counter_addsub

Overview:
- Parametrised, registered address/step counter for the counter subsystem.
- Generalises the fixed 9-bit ripple adder into a WIDTH-bit accumulator.
- Each enabled cycle it adds or subtracts a programmable step to a held count.
- Provides wrap or saturate overflow handling, registered carry/borrow, limit detection with optional auto-reload, and a synchronous load. Used for blitter/DSP address stepping.

Parameters:
- WIDTH, 9, count/step/limit width in bits (legal 2..32).
- RESET_VAL, 0, value of count after reset (WIDTH bits).

Ports:
- MasterClock  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- load  in  1  load count from load_val this cycle.
- load_val  in  WIDTH  load / auto-reload value.
- en  in  1  step enable.
- sub  in  1  0 = count+step, 1 = count-step.
- step  in  WIDTH  unsigned step magnitude.
- sat  in  1  0 = modulo-2^WIDTH wrap, 1 = saturate at 0 / all-ones.
- limit  in  WIDTH  terminal value.
- reload_en  in  1  on limit hit, reload load_val instead of the stepped value.
- count  out  WIDTH  current registered count.
- carry  out  1  registered carry (add) / borrow (sub) of last step.
- tc  out  1  one-cycle pulse: last step hit or crossed limit.
- busy_sat  out  1  high while count is clamped by saturation.

Behaviour:
- Reset, synchronous, active-high, top priority: count=RESET_VAL, carry=0, tc=0, busy_sat=0. Reset mid-step discards the step.
- Priority after reset: load > en > hold.
- load=1: count<=load_val; carry, tc and busy_sat are cleared; en is ignored that cycle.
- en=1, load=0: the next count is computed as follows, with a latency of 1 cycle (result visible the cycle after en).
  - Raw sum is WIDTH+1 bits: {0,count}+{0,step} (add) or {0,count}-{0,step} (sub).
  - Raw MSB is carry (add) or borrow (sub).
  - Wrap mode (sat=0): next = raw[WIDTH-1:0]; carry <= raw MSB; busy_sat <= 0.
  - Saturate mode (sat=1): on overflow, next = all-ones; on underflow, next = 0. busy_sat <= raw MSB; carry <= raw MSB.
  - Limit test is on the pre-clamp/pre-wrap mathematical result vs limit.
    - add: hit if count<limit and count+step>=limit, or count==limit and step==0.
    - sub: hit if count>limit and count-step<=limit, or count==limit and step==0.
    - A carry/borrow that wraps past limit counts as a hit.
  - On hit: tc<=1 for exactly one cycle. If reload_en=1, count<=load_val (overrides wrap/sat result, busy_sat<=0); carry still reflects raw MSB.
- en=0, load=0: count holds; tc<=0; carry and busy_sat hold.
- step=0 with en: count unchanged; carry=0; tc only if count==limit.
- Back-to-back en: one step per cycle, no bubbles. tc may assert on consecutive cycles.
- Inputs are sampled only at the clock edge; outputs are purely registered with no combinational paths to outputs.

Decomposition:
- Package cnt_pkg: typedef step_mode_e {WRAP=0, SAT=1}; function for WIDTH+1 add/sub; constant ALL_ONES(WIDTH).
- One combinational sub-module, addsub_core: WIDTH-bit add/subtract with carry/borrow out and limit-hit flag.
- The parent holds the registers and priority/saturation/reload logic.

Test Plan (WIDTH=9):
- Reset: RESET=1 for 1 cycle with RESET_VAL=0 -> count=0, carry=0, tc=0, busy_sat=0. Load 0x155 then RESET in the next cycle -> count=0.
- Wrap add: load 0x1F0, step=0x020, en 1 cycle -> count=0x010, carry=1, busy_sat=0. Further step -> count=0x030, carry=0.
- Saturate sub: load 0x005, sat=1, sub=1, step=0x008 -> count=0x000, carry=1, busy_sat=1. Add step 3 -> count=0x003, busy_sat=0.
- Limit with reload: load 0x000, limit=0x00A, step=4, reload_en=1, load_val=0x100, en 4 cycles -> counts 0x004, 0x008, 0x100 (tc pulse on that cycle only), 0x104.
- Priority: load=1 and en=1 same cycle with load_val=0x0AA -> count=0x0AA, no step applied, tc=0. RESET with load -> RESET_VAL.
- Random: 10k cycles vs reference model (WIDTH 9 and 16, all modes) -> exact match of count/carry/tc/busy_sat.
